// File: rtl/dtw_stream_feeder_pkg.sv
// Shared definitions for the DTW accelerator front end.
//   feeder_state_t : feeder control states
//   DTW_DATA_WIDTH : default sample width, shared with the accelerator
//   DTW_SIZE       : default samples per sequence (matrix is SIZE x SIZE)
//   idx_w()        : width of row/column/write counters for a given SIZE
//   addr_w()       : width of a sample-buffer address for a given SIZE
package dtw_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  localparam int DTW_DATA_WIDTH = 32;
  localparam int DTW_SIZE       = 2500;

  // One extra bit so a counter can hold the value SIZE (buffer full).
  function automatic int idx_w(input int size);
    return $clog2(size) + 1;
  endfunction

  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/dtw_stream_feeder_if.sv
// Handshake/data bundle between the feeder and its environment.
//   master : sample loader + job control (drives writes, start/hold/abort)
//   slave  : the feeder (drives ready flags, beat stream, busy/done)
interface dtw_stream_feeder_if
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH = DTW_DATA_WIDTH,
  parameter int IDX_W      = idx_w(DTW_SIZE)
);
  logic                  ref_in_valid;
  logic [DATA_WIDTH-1:0] ref_in_data;
  logic                  ref_in_ready;
  logic                  cam_in_valid;
  logic [DATA_WIDTH-1:0] cam_in_data;
  logic                  cam_in_ready;
  logic                  start;
  logic                  hold;
  logic                  abort;
  logic [DATA_WIDTH-1:0] refer;
  logic [DATA_WIDTH-1:0] camera;
  logic                  ready;
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic                  busy;
  logic                  done;

  modport master (
    output ref_in_valid, ref_in_data, cam_in_valid, cam_in_data,
    output start, hold, abort,
    input  ref_in_ready, cam_in_ready,
    input  refer, camera, ready, row, col, busy, done
  );

  modport slave (
    input  ref_in_valid, ref_in_data, cam_in_valid, cam_in_data,
    input  start, hold, abort,
    output ref_in_ready, cam_in_ready,
    output refer, camera, ready, row, col, busy, done
  );
endinterface

// File: rtl/dtw_sample_buffer.sv
// Simple dual-port sample RAM, DEPTH x WIDTH, no reset on the array.
//   clk              : clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata  : synchronous read port, data one cycle after address
module dtw_sample_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2500,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dtw_stream_feeder.sv
// Upstream feeder for the DTW accelerator. Captures a reference and a
// camera sequence (SIZE samples each) and replays them row-major: the
// reference sample is held for a whole row while the camera sample
// advances every beat. One beat per cycle unless hold is high.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_feed    : loader writes, start/hold/abort, beat stream, busy/done
module dtw_stream_feeder
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH = DTW_DATA_WIDTH,
  parameter int SIZE       = DTW_SIZE,
  parameter int IDX_W      = idx_w(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  dtw_stream_feeder_if.slave io_feed
);
  localparam int               AW   = addr_w(SIZE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] FULL = IDX_W'(SIZE);

  feeder_state_t         r_state;
  logic [IDX_W-1:0]      r_ref_wr, r_cam_wr;
  logic [IDX_W-1:0]      r_rd_i, r_rd_j;
  logic [IDX_W-1:0]      r_rd_i_p1, r_rd_j_p1;
  logic [DATA_WIDTH-1:0] r_refer, r_camera;
  logic [IDX_W-1:0]      r_row, r_col;
  logic                  r_ready, r_done;

  logic                  w_ref_rdy, w_cam_rdy, w_ref_we, w_cam_we;
  logic                  w_stall, w_last_beat;
  logic [AW-1:0]         w_raddr_i, w_raddr_j;
  logic [IDX_W-1:0]      w_nxt_i, w_nxt_j;
  logic [DATA_WIDTH-1:0] w_ref_q, w_cam_q;

  assign w_ref_rdy = (r_state == LOAD) && (r_ref_wr < FULL);
  assign w_cam_rdy = (r_state == LOAD) && (r_cam_wr < FULL);
  assign w_ref_we  = io_feed.ref_in_valid && w_ref_rdy;
  assign w_cam_we  = io_feed.cam_in_valid && w_cam_rdy;

  // While stalled, re-read the pending beat's address so the RAM output
  // keeps matching r_rd_*_p1 and the beat replays unchanged on release.
  assign w_stall   = (r_state == STREAM) && io_feed.hold;
  assign w_raddr_i = w_stall ? r_rd_i_p1[AW-1:0] : r_rd_i[AW-1:0];
  assign w_raddr_j = w_stall ? r_rd_j_p1[AW-1:0] : r_rd_j[AW-1:0];

  // Row-major advance, saturating at (SIZE-1, SIZE-1).
  assign w_nxt_j = (r_rd_j == LAST) ? ((r_rd_i == LAST) ? r_rd_j : '0)
                                    : r_rd_j + 1'b1;
  assign w_nxt_i = ((r_rd_j == LAST) && (r_rd_i != LAST)) ? r_rd_i + 1'b1
                                                          : r_rd_i;
  assign w_last_beat = (r_rd_i_p1 == LAST) && (r_rd_j_p1 == LAST);

  dtw_sample_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(SIZE), .AW(AW)) u_ref_buf (
    .clk     (clk),
    .i_we    (w_ref_we),
    .i_waddr (r_ref_wr[AW-1:0]),
    .i_wdata (io_feed.ref_in_data),
    .i_raddr (w_raddr_i),
    .o_rdata (w_ref_q)
  );

  dtw_sample_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(SIZE), .AW(AW)) u_cam_buf (
    .clk     (clk),
    .i_we    (w_cam_we),
    .i_waddr (r_cam_wr[AW-1:0]),
    .i_wdata (io_feed.cam_in_data),
    .i_raddr (w_raddr_j),
    .o_rdata (w_cam_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_ref_wr  <= '0;
      r_cam_wr  <= '0;
      r_rd_i    <= '0;
      r_rd_j    <= '0;
      r_rd_i_p1 <= '0;
      r_rd_j_p1 <= '0;
      r_refer   <= '0;
      r_camera  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else if (io_feed.abort) begin
      r_state   <= LOAD;
      r_ref_wr  <= '0;
      r_cam_wr  <= '0;
      r_rd_i    <= '0;
      r_rd_j    <= '0;
      r_rd_i_p1 <= '0;
      r_rd_j_p1 <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      if (w_ref_we) r_ref_wr <= r_ref_wr + 1'b1;
      if (w_cam_we) r_cam_wr <= r_cam_wr + 1'b1;
      case (r_state)
        LOAD: begin
          if (io_feed.start && (r_ref_wr == FULL) && (r_cam_wr == FULL)) begin
            r_state <= PRIME;
            r_rd_i  <= '0;
            r_rd_j  <= '0;
          end
        end
        // Stage 0 -> 1: address (0,0) enters the RAMs.
        PRIME: begin
          r_rd_i_p1 <= r_rd_i;
          r_rd_j_p1 <= r_rd_j;
          r_rd_i    <= w_nxt_i;
          r_rd_j    <= w_nxt_j;
          r_state   <= STREAM;
        end
        // Stage 1 -> 2: RAM data plus delayed indices become the beat.
        STREAM: begin
          if (!io_feed.hold) begin
            r_refer  <= w_ref_q;
            r_camera <= w_cam_q;
            r_row    <= r_rd_i_p1;
            r_col    <= r_rd_j_p1;
            r_ready  <= 1'b1;
            if (w_last_beat) begin
              r_state <= DONE;
            end else begin
              r_rd_i_p1 <= r_rd_i;
              r_rd_j_p1 <= r_rd_j;
              r_rd_i    <= w_nxt_i;
              r_rd_j    <= w_nxt_j;
            end
          end
        end
        DONE: begin
          r_done   <= 1'b1;
          r_ref_wr <= '0;
          r_cam_wr <= '0;
          r_state  <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign io_feed.ref_in_ready = w_ref_rdy;
  assign io_feed.cam_in_ready = w_cam_rdy;
  assign io_feed.refer        = r_refer;
  assign io_feed.camera       = r_camera;
  assign io_feed.ready        = r_ready;
  assign io_feed.row          = r_row;
  assign io_feed.col          = r_col;
  assign io_feed.busy         = (r_state != LOAD);
  assign io_feed.done         = r_done;
endmodule

// File: tb/tb_dtw_stream_feeder.sv
module tb_dtw_stream_feeder;
  import dtw_pkg::*;

  localparam int DW = 32;
  localparam int S  = 4;
  localparam int IW = idx_w(S);

  localparam int P_IDLE = 0, P_LEAD = 1, P_RUN = 2, P_FIN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtw_stream_feeder_if #(.DATA_WIDTH(DW), .IDX_W(IW)) fif ();

  dtw_stream_feeder #(.DATA_WIDTH(DW), .SIZE(S), .IDX_W(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_feed (fif.slave)
  );

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int dones    = 0;

  // Transaction-level model: buffers as arrays, stream as a beat index k.
  int          phase, k, rcnt, ccnt;
  logic [DW-1:0] rmem [S];
  logic [DW-1:0] cmem [S];
  logic [DW-1:0] e_refer, e_camera;
  int          e_row, e_col;
  bit          e_ready, e_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE; k = 0; rcnt = 0; ccnt = 0;
    e_refer = '0; e_camera = '0; e_row = 0; e_col = 0;
    e_ready = 0; e_done = 0;
  endtask

  task automatic model_edge();
    bit start_ok;
    if (!rst_n) begin model_reset(); return; end
    if (fif.abort) begin
      phase = P_IDLE; rcnt = 0; ccnt = 0; e_row = 0; e_col = 0;
      e_ready = 0; e_done = 0;
      return;
    end
    e_ready = 0; e_done = 0;
    case (phase)
      P_IDLE: begin
        start_ok = fif.start && rcnt == S && ccnt == S;
        if (fif.ref_in_valid && rcnt < S) begin rmem[rcnt] = fif.ref_in_data; rcnt++; end
        if (fif.cam_in_valid && ccnt < S) begin cmem[ccnt] = fif.cam_in_data; ccnt++; end
        if (start_ok) begin phase = P_LEAD; k = 0; end
      end
      P_LEAD: phase = P_RUN;
      P_RUN: if (!fif.hold) begin
        e_ready = 1; e_row = k / S; e_col = k % S;
        e_refer = rmem[e_row]; e_camera = cmem[e_col];
        k++;
        if (k == S * S) phase = P_FIN;
      end
      default: begin
        e_done = 1; rcnt = 0; ccnt = 0; phase = P_IDLE;
      end
    endcase
  endtask

  task automatic check_all();
    check("ready", fif.ready, e_ready);
    check("done", fif.done, e_done);
    check("busy", fif.busy, phase != P_IDLE);
    check("ref_in_ready", fif.ref_in_ready, phase == P_IDLE && rcnt < S);
    check("cam_in_ready", fif.cam_in_ready, phase == P_IDLE && ccnt < S);
    check("refer", fif.refer, e_refer);
    check("camera", fif.camera, e_camera);
    check("row", fif.row, e_row);
    check("col", fif.col, e_col);
    if (fif.ready === 1'b1) beats++;
    if (fif.done === 1'b1) dones++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    fif.ref_in_valid = 0; fif.ref_in_data = '0;
    fif.cam_in_valid = 0; fif.cam_in_data = '0;
    fif.start = 0; fif.hold = 0; fif.abort = 0;
  endtask

  // Loads nref/ncam samples; fixed pattern 10,20,.. / 1,2,.. or random.
  task automatic load(input int nref, input int ncam, input bit rnd);
    int n;
    n = (nref > ncam) ? nref : ncam;
    for (int i = 0; i < n; i++) begin
      fif.ref_in_valid = (i < nref);
      fif.cam_in_valid = (i < ncam);
      fif.ref_in_data  = rnd ? DW'($urandom) : DW'(10 * (i + 1));
      fif.cam_in_data  = rnd ? DW'($urandom) : DW'(i + 1);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic pulse_start();
    fif.start = 1; cycle(); fif.start = 0;
  endtask

  task automatic run_job(input string tag, input int hold_pct);
    beats = 0; dones = 0;
    pulse_start();
    for (int c = 0; c < 200 && phase != P_IDLE; c++) begin
      fif.hold = ($urandom_range(0, 99) < hold_pct);
      cycle();
    end
    fif.hold = 0;
    check({tag, "_beats"}, beats, S * S);
    check({tag, "_dones"}, dones, 1);
  endtask

  initial begin
    int  hl;
    bit  want, fire;
    idle_inputs();
    model_reset();

    // Reset state
    cycle(); cycle();
    check("rst_ready", fif.ready, 0);
    check("rst_busy", fif.busy, 0);
    check("rst_ref_in_ready", fif.ref_in_ready, 1);
    check("rst_cam_in_ready", fif.cam_in_ready, 1);
    rst_n = 1;
    cycle();

    // Basic job with fixed pattern
    load(S, S, 0);
    run_job("basic", 0);

    // Start with a partial reference buffer is ignored
    load(3, S, 1);
    pulse_start();
    cycle();
    check("partial_busy", fif.busy, 0);
    check("partial_ready", fif.ready, 0);
    fif.ref_in_valid = 1; fif.ref_in_data = DW'($urandom); cycle(); idle_inputs();
    run_job("after_fill", 30);

    // Hold for 3 cycles at beat (1,2)
    load(S, S, 0);
    beats = 0; dones = 0;
    pulse_start();
    hl = 3; want = 0;
    for (int c = 0; c < 60 && phase != P_IDLE; c++) begin
      fif.hold = (phase == P_RUN && k == 6 && hl > 0);
      fire = want && !fif.hold;
      if (fif.hold) begin hl--; if (hl == 0) want = 1; end
      cycle();
      if (fire) begin
        check("hold_row", fif.row, 1);
        check("hold_col", fif.col, 2);
        check("hold_refer", fif.refer, 20);
        check("hold_camera", fif.camera, 3);
        want = 0;
      end
    end
    fif.hold = 0;
    check("hold_beats", beats, S * S);
    check("hold_dones", dones, 1);

    // Five reference writes with valid held high: only four land
    for (int i = 0; i < 5; i++) begin
      fif.ref_in_valid = 1; fif.ref_in_data = DW'(100 + i);
      fif.cam_in_valid = (i < S); fif.cam_in_data = DW'(200 + i);
      cycle();
      if (i == 3) check("ref_full_ready", fif.ref_in_ready, 0);
    end
    idle_inputs();
    run_job("overflow", 0);
    check("overflow_last_refer", fif.refer, 103);

    // Abort at beat (2,1)
    load(S, S, 1);
    beats = 0; dones = 0;
    pulse_start();
    for (int c = 0; c < 40 && phase != P_IDLE; c++) begin
      fif.abort = (phase == P_RUN && k == 9);
      fire = fif.abort;
      cycle();
      fif.abort = 0;
      if (fire) begin
        check("abort_ready", fif.ready, 0);
        check("abort_busy", fif.busy, 0);
        check("abort_ref_in_ready", fif.ref_in_ready, 1);
        check("abort_cam_in_ready", fif.cam_in_ready, 1);
      end
    end
    repeat (5) cycle();
    check("abort_beats", beats, 9);
    check("abort_dones", dones, 0);
    load(S, S, 1);
    run_job("post_abort", 20);

    // Abort together with the final beat: no done pulse
    load(S, S, 1);
    beats = 0; dones = 0;
    pulse_start();
    for (int c = 0; c < 40 && phase != P_IDLE; c++) begin
      fif.abort = (phase == P_RUN && k == S * S - 1);
      cycle();
      fif.abort = 0;
    end
    repeat (3) cycle();
    check("abort_last_beats", beats, S * S - 1);
    check("abort_last_dones", dones, 0);

    // Asynchronous reset mid-stream
    load(S, S, 1);
    pulse_start();
    repeat (8) cycle();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("arst_ready", fif.ready, 0);
    check("arst_busy", fif.busy, 0);
    check("arst_refer", fif.refer, 0);
    check("arst_camera", fif.camera, 0);
    check("arst_row", fif.row, 0);
    check("arst_col", fif.col, 0);
    cycle();
    rst_n = 1;
    beats = 0;
    pulse_start();
    repeat (6) cycle();
    check("arst_start_ignored", beats, 0);

    // Random jobs with random hold
    for (int j = 0; j < 3; j++) begin
      load(S, S, 1);
      run_job("random", 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
